// File: rtl/mov_sum_pkg.sv
// Shared helpers for the moving-sum family: width derivation and sample widening.
package mov_sum_pkg;

    // Ceiling log2, with clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >>> 1;
        end
        return r;
    endfunction

    // Exact width of a sum of win samples of dw bits, with one sign bit.
    function automatic int sum_width(input int dw, input int win);
        return dw + clog2(win) + 1;
    endfunction

    // Widen a w-bit sample to 64 bits, sign- or zero-extending.
    // Callers truncate the result to their own accumulator width.
    function automatic logic [63:0] ext_w(input logic [63:0] v, input int w, input logic sgn);
        logic [63:0] mask;
        mask = ~64'd0 << w;
        if (sgn && v[w-1])
            return v | mask;
        else
            return v & ~mask;
    endfunction

endpackage

// File: rtl/mov_sum_win_delay_ram.sv
// WIN x DW delay line: single port, asynchronous read, so the word being
// overwritten is visible in the same cycle as the write.
module delay_ram #(
    parameter int DW    = 17,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mov_sum_win.sv
// Sliding-window moving sum over the last min(n, WIN) accepted samples.
// A fill counter masks stale buffer entries after reset or restart.
module mov_sum_win
    import mov_sum_pkg::*;
#(
    parameter int DW     = 17,
    parameter int WIN    = 64,
    parameter bit SIGNED = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ena,
    input  logic                                 clr,
    input  logic [DW-1:0]                        din,
    output logic signed [sum_width(DW, WIN)-1:0] sum_out,
    output logic                                 full,
    output logic                                 sum_vld
);

    localparam int SW = sum_width(DW, WIN);
    localparam int AW = clog2(WIN);
    localparam int CW = clog2(WIN + 1);

    logic [AW-1:0]        wp;
    logic [AW-1:0]        wp_next;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic                 cnt_full;
    logic [DW-1:0]        old;
    logic signed [SW-1:0] din_x;
    logic signed [SW-1:0] old_x;
    logic signed [SW-1:0] sum_next;

    delay_ram #(
        .DW    (DW),
        .DEPTH (WIN),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ena && !rst),
        .addr  (wp),
        .wdata (din),
        .rdata (old)
    );

    // Next-state arithmetic for an accepted sample.
    always_comb begin
        din_x    = SW'(ext_w(64'(din), DW, SIGNED));
        old_x    = SW'(ext_w(64'(old), DW, SIGNED));
        cnt_full = (cnt == CW'(WIN));
        wp_next  = (wp == AW'(WIN - 1)) ? '0 : wp + AW'(1);
        cnt_next = cnt_full ? cnt : cnt + CW'(1);
        sum_next = sum_out + din_x - (cnt_full ? old_x : '0);
    end

    // Pointer, fill counter, accumulator and output flags; rst > clr > ena.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= '0;
            cnt     <= '0;
            sum_out <= '0;
            full    <= 1'b0;
            sum_vld <= 1'b0;
        end else if (clr) begin
            full    <= 1'b0;
            sum_vld <= 1'b0;
            if (ena) begin
                sum_out <= din_x;
                cnt     <= CW'(1);
                wp      <= wp_next;
            end else begin
                sum_out <= '0;
                cnt     <= '0;
            end
        end else if (ena) begin
            sum_out <= sum_next;
            cnt     <= cnt_next;
            wp      <= wp_next;
            full    <= (cnt_next == CW'(WIN));
            sum_vld <= (cnt_next == CW'(WIN));
        end else begin
            sum_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mov_sum_win.sv
// Bench for mov_sum_win: WIN=4 unsigned instance against a history-queue model,
// plus WIN=64 signed and unsigned instances for the extreme-value sums.
module tb_mov_sum_win;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        ena_a = 1'b0;
    logic        clr_a = 1'b0;
    logic [16:0] din_a = '0;
    logic signed [19:0] sum_a;
    logic        full_a;
    logic        vld_a;

    logic        ena_w = 1'b0;
    logic [16:0] din_b = '0;
    logic [16:0] din_c = '0;
    logic signed [23:0] sum_b;
    logic signed [23:0] sum_c;
    logic        full_b, full_c, vld_b, vld_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic signed [23:0] s;
        logic               f;
        logic               v;
    } exp_t;

    exp_t      sb[$];
    longint    hist[$];
    exp_t      last_exp = '{s: 24'sd0, f: 1'b0, v: 1'b0};

    always #5 clk = ~clk;

    mov_sum_win #(.DW(17), .WIN(4), .SIGNED(1'b0)) dut_a (
        .clk(clk), .rst(rst), .ena(ena_a), .clr(clr_a), .din(din_a),
        .sum_out(sum_a), .full(full_a), .sum_vld(vld_a)
    );

    mov_sum_win #(.DW(17), .WIN(64), .SIGNED(1'b1)) dut_b (
        .clk(clk), .rst(rst), .ena(ena_w), .clr(1'b0), .din(din_b),
        .sum_out(sum_b), .full(full_b), .sum_vld(vld_b)
    );

    mov_sum_win #(.DW(17), .WIN(64), .SIGNED(1'b0)) dut_c (
        .clk(clk), .rst(rst), .ena(ena_w), .clr(1'b0), .din(din_c),
        .sum_out(sum_c), .full(full_c), .sum_vld(vld_c)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model for dut_a: keep the accepted samples of the current window.
    task automatic model(input logic r, input logic e, input logic c, input logic [16:0] d);
        exp_t   x;
        longint s;
        x = last_exp;
        if (r) begin
            hist.delete();
            x = '{s: 24'sd0, f: 1'b0, v: 1'b0};
        end else if (c) begin
            hist.delete();
            if (e) hist.push_back(longint'(d));
            x.f = 1'b0;
            x.v = 1'b0;
        end else if (e) begin
            hist.push_back(longint'(d));
            if (hist.size() > 4) void'(hist.pop_front());
            x.f = (hist.size() == 4);
            x.v = x.f;
        end else begin
            x.v = 1'b0;
        end
        if (r || c || e) begin
            s = 0;
            foreach (hist[i]) s += hist[i];
            x.s = 24'(s);
        end
        last_exp = x;
        sb.push_back(x);
    endtask

    // One clock of stimulus on dut_a, then compare its registered outputs.
    task automatic step(input string tag, input logic r, input logic e, input logic c, input logic [16:0] d);
        exp_t x;
        @(negedge clk);
        rst   = r;
        ena_a = e;
        clr_a = c;
        din_a = d;
        model(r, e, c, d);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({tag, ".sum"},  sum_a,  x.s);
        chk({tag, ".full"}, full_a, x.f);
        chk({tag, ".vld"},  vld_a,  x.v);
    endtask

    initial begin
        // Reset held two cycles with a live strobe, then one cycle after.
        step("rst0", 1'b1, 1'b1, 1'b0, 17'd5);
        step("rst1", 1'b1, 1'b1, 1'b0, 17'd5);
        step("rst_after", 1'b0, 1'b0, 1'b0, 17'd5);
        chk("rst_b.sum", sum_b, 0);
        chk("rst_c.full", full_c, 0);

        // Fill.
        step("fill1", 1'b0, 1'b1, 1'b0, 17'd1);
        step("fill2", 1'b0, 1'b1, 1'b0, 17'd2);
        step("fill3", 1'b0, 1'b1, 1'b0, 17'd3);
        step("fill4", 1'b0, 1'b1, 1'b0, 17'd4);
        chk("fill4.const", sum_a, 10);

        // Steady state with an idle gap after sample 5; covers pointer wrap.
        step("wrap5", 1'b0, 1'b1, 1'b0, 17'd5);
        for (int i = 0; i < 3; i++) step("gap", 1'b0, 1'b0, 1'b0, 17'd99);
        chk("gap.const", sum_a, 14);
        step("wrap6", 1'b0, 1'b1, 1'b0, 17'd6);
        chk("wrap6.const", sum_a, 18);
        step("wrap7", 1'b0, 1'b1, 1'b0, 17'd7);
        step("wrap8", 1'b0, 1'b1, 1'b0, 17'd8);
        step("wrap9", 1'b0, 1'b1, 1'b0, 17'd9);
        chk("wrap9.const", sum_a, 30);

        // Restart with a sample, then zeros until stale data would otherwise show.
        step("clr_ena", 1'b0, 1'b1, 1'b1, 17'd7);
        chk("clr_ena.const", sum_a, 7);
        step("clr_z1", 1'b0, 1'b1, 1'b0, 17'd0);
        step("clr_z2", 1'b0, 1'b1, 1'b0, 17'd0);
        step("clr_z3", 1'b0, 1'b1, 1'b0, 17'd0);
        chk("clr_z3.full", full_a, 1);
        step("clr_z4", 1'b0, 1'b1, 1'b0, 17'd0);
        chk("clr_z4.const", sum_a, 0);

        // Restart without a sample.
        step("clr_only", 1'b0, 1'b0, 1'b1, 17'd50);
        step("after_clr", 1'b0, 1'b1, 1'b0, 17'd3);

        // Mid-stream reset: earlier samples must not reappear.
        step("pre_rst1", 1'b0, 1'b1, 1'b0, 17'd9);
        step("pre_rst2", 1'b0, 1'b1, 1'b0, 17'd9);
        step("mid_rst", 1'b1, 1'b0, 1'b0, 17'd0);
        for (int i = 0; i < 5; i++) step("post_rst", 1'b0, 1'b1, 1'b0, 17'd1);
        chk("post_rst.const", sum_a, 4);

        // Random strobes and samples, including near-maximum values.
        for (int i = 0; i < 60; i++)
            step("rand", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                 17'($urandom_range(0, 131071)));

        // Extremes on the 64-deep instances.
        @(negedge clk);
        ena_a = 1'b0;
        clr_a = 1'b0;
        din_b = 17'h10000;
        din_c = 17'h1FFFF;
        ena_w = 1'b1;
        for (int i = 0; i < 63; i++) @(posedge clk);
        #1;
        chk("ext63.full_b", full_b, 0);
        chk("ext63.vld_c", vld_c, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("ext64.sum_b", sum_b, -64'sd4194304);
        chk("ext64.full_b", full_b, 1);
        chk("ext64.vld_b", vld_b, 1);
        chk("ext64.sum_c", sum_c, 64'sd8388544);
        chk("ext64.full_c", full_c, 1);
        @(negedge clk);
        ena_w = 1'b0;
        @(posedge clk);
        #1;
        chk("ext_idle.vld_b", vld_b, 0);
        chk("ext_idle.sum_c", sum_c, 64'sd8388544);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
